// File: rtl/mopshub_demux_pkg.sv
// Shared constants and FSM state type for the 1-to-16 handshaked demultiplexer.
// The block distributes 16-bit words to 16 channels.
package mopshub_demux_pkg;

    localparam int NUM_CH = 16;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/demux_timeout_cnt.sv
// Acknowledge-timeout counter. Clear has priority over enable.
// o_tc is high while the count sits at TIMEOUT_CYC-1.
module demux_timeout_cnt #(
    parameter int TO_W        = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/demux1_16_16bit_hs.sv
// 1-to-16 demultiplexer for 16-bit words with a per-channel valid/ack handshake.
// A word waits for an ack on its channel, with a timeout.
module demux1_16_16bit_hs
    import mopshub_demux_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TO_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ack,
    output logic                     busy,
    output logic                     err_sel,
    output logic                     err_timeout,
    output logic [SEL_W-1:0]         err_chan,
    output logic [1:0]               dbg_state
);

    // Upstream handshake: a word is consumed on a rising edge where in_valid
    // and in_ready are both high; in_ready is high only in IDLE outside reset.
    state_t                     r_state;
    state_t                     w_next;
    logic [NUM_CH*DATA_W-1:0]   r_data_out;
    logic [NUM_CH-1:0]          r_out_valid;
    logic [3:0]                 r_chan;
    logic                       r_err_sel;
    logic                       r_err_timeout;
    logic [SEL_W-1:0]           r_err_chan;
    logic                       w_sel_ok;
    logic                       w_ack;
    logic                       w_tc;
    logic                       w_cnt_clear;
    logic                       w_cnt_en;

    assign w_sel_ok = (sel[SEL_W-1] == 1'b0);
    assign w_ack    = out_ack[r_chan];

    demux_timeout_cnt #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .o_tc     (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_clear = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && w_sel_ok) begin
                    w_next      = DRIVE;
                    w_cnt_clear = 1'b1;
                end
            end
            DRIVE: begin
                w_cnt_en = 1'b1;
                if (w_ack || w_tc) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Ack is checked before the terminal count so a coincident ack completes normally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data_out    <= '0;
            r_out_valid   <= '0;
            r_chan        <= '0;
            r_err_sel     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_chan    <= '0;
        end else begin
            r_err_sel     <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_sel_ok) begin
                            r_data_out[{sel[3:0], 4'b0000} +: DATA_W] <= data_in;
                            r_out_valid <= NUM_CH'(1) << sel[3:0];
                            r_chan      <= sel[3:0];
                        end else begin
                            r_err_sel  <= 1'b1;
                            r_err_chan <= sel;
                        end
                    end
                end
                DRIVE: begin
                    if (w_ack) begin
                        r_out_valid <= '0;
                    end else if (w_tc) begin
                        r_out_valid   <= '0;
                        r_err_timeout <= 1'b1;
                        r_err_chan    <= {1'b0, r_chan};
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = rst && (r_state == IDLE);
    assign busy        = (r_state == DRIVE);
    assign data_out    = r_data_out;
    assign out_valid   = r_out_valid;
    assign err_sel     = r_err_sel;
    assign err_timeout = r_err_timeout;
    assign err_chan    = r_err_chan;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_demux1_16_16bit_hs.sv
// Bench for demux1_16_16bit_hs: vector table, hand-written corner sequences
// and random words against a per-channel memory model.
module tb_demux1_16_16bit_hs;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [15:0]  data_in = '0;
    logic [4:0]   sel = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] data_out;
    logic [15:0]  out_valid;
    logic [15:0]  out_ack = '0;
    logic         busy;
    logic         err_sel;
    logic         err_timeout;
    logic [4:0]   err_chan;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mdl_mem [16];
    logic [4:0]  mdl_err_chan;
    logic [20:0] exp_q[$];

    typedef struct {
        logic [4:0]  sel;
        logic [15:0] data;
        int          ack_at;
        int          exp_cyc;
        bit          exp_tmo;
        bit          exp_errsel;
    } vec_t;

    vec_t vecs [7];

    demux1_16_16bit_hs #(
        .TIMEOUT_CYC (TO),
        .TO_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .sel         (sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ack     (out_ack),
        .busy        (busy),
        .err_sel     (err_sel),
        .err_timeout (err_timeout),
        .err_chan    (err_chan),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mdl_flat();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = mdl_mem[i];
        return r;
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
        mdl_err_chan = '0;
        exp_q.delete();
    endfunction

    // Drives one word and follows its handshake until the block is back in IDLE.
    task automatic send_word(input logic [4:0] s, input logic [15:0] d, input int ack_at,
                             input logic [15:0] noise, output int cycles,
                             output bit saw_tmo, output bit saw_errsel);
        int          waitc;
        logic [15:0] onehot;
        waitc  = 0;
        onehot = 16'd1 << s[3:0];
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("in_ready_wait", in_ready, 1);
        data_in  = d;
        sel      = s;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        data_in    = 16'($urandom);
        sel        = 5'($urandom);
        saw_errsel = err_sel;
        saw_tmo    = 1'b0;
        cycles     = 0;
        if (s <= 5'd15) begin
            while (out_valid !== 16'd0 && cycles < TO + 3) begin
                check("drive_valid", out_valid, onehot);
                check("drive_busy", busy, 1);
                check("drive_ready", in_ready, 0);
                cycles++;
                out_ack = (noise & ~onehot) | ((cycles == ack_at) ? onehot : 16'd0);
                @(negedge clk);
            end
            out_ack = '0;
            saw_tmo = err_timeout;
            check("done_ready", in_ready, 0);
            check("done_busy", busy, 0);
            @(negedge clk);
            check("tmo_one_cycle", err_timeout, 0);
        end else begin
            check("badsel_ready", in_ready, 1);
            check("badsel_valid", out_valid, 0);
        end
    endtask

    task automatic run_word(input string tag, input logic [4:0] s, input logic [15:0] d,
                            input int ack_at, input logic [15:0] noise, input int exp_cyc,
                            input bit exp_tmo, input bit exp_errsel);
        int          cyc;
        bit          tmo;
        bit          es;
        logic [20:0] item;
        if (s > 5'd15) begin
            mdl_err_chan = s;
        end else begin
            mdl_mem[s[3:0]] = d;
            if (exp_tmo) mdl_err_chan = s;
            else exp_q.push_back({s[3:0], d});
        end
        send_word(s, d, ack_at, noise, cyc, tmo, es);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_tmo"}, tmo, exp_tmo);
        check({tag, "_errsel"}, es, exp_errsel);
        check({tag, "_errchan"}, err_chan, mdl_err_chan);
        check({tag, "_data"}, data_out, mdl_flat());
        if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            check({tag, "_sb"}, data_out[16*item[19:16] +: 16], item[15:0]);
        end
    endtask

    initial begin
        int          ok;
        int          ack_at;
        int          exp_cyc;
        logic [4:0]  s;
        logic [15:0] d;

        vecs[0] = '{5'd3,  16'hA5A5, 1, 1, 1'b0, 1'b0};
        vecs[1] = '{5'd0,  16'h1111, 3, 3, 1'b0, 1'b0};
        vecs[2] = '{5'd15, 16'hFFFF, 0, 8, 1'b1, 1'b0};
        vecs[3] = '{5'd7,  16'h0707, 8, 8, 1'b0, 1'b0};
        vecs[4] = '{5'd20, 16'hDEAD, 1, 0, 1'b0, 1'b1};
        vecs[5] = '{5'd31, 16'hBEEF, 0, 0, 1'b0, 1'b1};
        vecs[6] = '{5'd10, 16'h0A0A, 9, 8, 1'b1, 1'b0};

        mdl_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_errchan", err_chan, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_ready", in_ready, 1);

        // Basic delivery on channel 3 with ack in the first DRIVE cycle.
        data_in  = 16'hA5A5;
        sel      = 5'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("basic_valid", out_valid, 16'h0008);
        check("basic_slice", data_out[63:48], 16'hA5A5);
        out_ack = 16'h0008;
        @(negedge clk);
        out_ack = '0;
        check("basic_clear", out_valid, 0);
        check("basic_done_ready", in_ready, 0);
        @(negedge clk);
        check("basic_idle_ready", in_ready, 1);
        mdl_mem[3] = 16'hA5A5;

        for (int i = 0; i < 7; i++) begin
            run_word($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].ack_at,
                     16'h0000, vecs[i].exp_cyc, vecs[i].exp_tmo, vecs[i].exp_errsel);
        end

        // Ack on a neighbouring channel must not complete a word on channel 7.
        run_word("wrongack", 5'd7, 16'h7777, 5, 16'h0040, 5, 1'b0, 1'b0);

        // Reset in the middle of a DRIVE on channel 2.
        data_in  = 16'h1234;
        sel      = 5'd2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_valid", out_valid, 16'h0004);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_valid0", out_valid, 0);
        check("mid_data0", data_out, 0);
        check("mid_slice2", data_out[47:32], 0);
        check("mid_tmo", err_timeout, 0);
        check("mid_errsel", err_sel, 0);
        check("mid_errchan", err_chan, 0);
        check("mid_busy", busy, 0);
        check("mid_ready", in_ready, 0);
        rst = 1'b1;
        mdl_reset();
        @(negedge clk);
        check("mid_rel_ready", in_ready, 1);

        for (int i = 0; i < 40; i++) begin
            s       = 5'($urandom_range(0, 19));
            d       = 16'($urandom);
            ack_at  = int'($urandom_range(0, TO + 1));
            ok      = (ack_at >= 1 && ack_at <= TO) ? 1 : 0;
            exp_cyc = (s > 5'd15) ? 0 : ((ok == 1) ? ack_at : TO);
            run_word($sformatf("rnd%0d", i), s, d, ack_at, 16'($urandom), exp_cyc,
                     (s <= 5'd15) && (ok == 0), s > 5'd15);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1_16_16bit_hs.md
DEMUX1_16_16BIT_HS -- requirements
Module: demux1_16_16bit_hs

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000, is the number of cycles to wait for a channel acknowledge before the word is abandoned.
REQ-002 Parameter TO_W, default 16, is the timeout counter width; TIMEOUT_CYC SHALL be less than 2^TO_W.
REQ-003 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 data_in  input  16  word to distribute.
REQ-006 sel  input  5  destination channel, sampled with data_in.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 data_out  output  256  per-channel data; channel n occupies bits [16n+15:16n].
REQ-010 out_valid  output  16  per-channel valid, one-hot or zero.
REQ-011 out_ack  input  16  per-channel acknowledge.
REQ-012 busy  output  1  a word is in flight.
REQ-013 err_sel  output  1  one-cycle pulse: a word with sel>15 was dropped.
REQ-014 err_timeout  output  1  one-cycle pulse: a word was abandoned on timeout.
REQ-015 err_chan  output  5  channel of the last error; holds until the next error.

Function
REQ-016 The FSM SHALL have three states: IDLE, DRIVE and DONE.
REQ-017 IDLE behaviour:
- in_ready=1.
- When in_valid=1 and sel<=15, latch data_in into channel sel's data_out slice, set out_valid[sel] on the next edge, load the counter with 0, and go to DRIVE.
REQ-018 IDLE with in_valid=1 and sel>15:
- Accept (consume) the word.
- Leave data_out and out_valid unchanged.
- Pulse err_sel, set err_chan=sel, and stay in IDLE.
REQ-019 Latency: out_valid[sel] SHALL rise one cycle after the accepting edge.
REQ-020 DRIVE behaviour:
- in_ready=0 and busy=1.
- The counter increments every cycle.
- out_ack bits of non-selected channels SHALL be ignored.
REQ-021 DRIVE with out_ack[sel]=1 sampled: clear out_valid on the next edge and go to DONE.
REQ-022 DRIVE with the counter at TIMEOUT_CYC-1 and no ack:
- Clear out_valid and pulse err_timeout.
- Set err_chan=sel and go to DONE.
REQ-023 If ack and timeout coincide in the same cycle, ack SHALL win and no err_timeout pulse is issued.
REQ-024 DONE SHALL last exactly one cycle, with in_ready=0 and busy=0, then return to IDLE; back-to-back throughput is therefore one word per 3 cycles minimum.
REQ-025 data_out slices SHALL hold the last value delivered to each channel; unselected slices never change.
REQ-026 in_valid asserted while in_ready=0 SHALL NOT be consumed; upstream must hold it.

Reset
REQ-027 When rst=0 at a clock edge, the block SHALL force:
- state=IDLE;
- data_out=0, out_valid=0;
- err_sel=0, err_timeout=0, err_chan=0, busy=0;
- the counter to 0.
REQ-028 in_ready SHALL be 0 while rst=0 and 1 on the first cycle after release.
REQ-029 Reset asserted during DRIVE SHALL abandon the word with no error pulse; out_valid drops on that edge.

Structure
REQ-030 Package mopshub_demux_pkg SHALL hold:
- NUM_CH=16, DATA_W=16, SEL_W=5;
- the FSM state enum.
REQ-031 The timeout counter SHALL be the sub-module demux_timeout_cnt, with clear, enable and terminal-count output, parameterised by TO_W and TIMEOUT_CYC.

Verification
REQ-032 Basic delivery: reset, then data_in=16'hA5A5, sel=3, in_valid=1 -> out_valid=16'h0008 next cycle, data_out[63:48]=16'hA5A5; out_ack[3]=1 -> out_valid=0 next cycle, in_ready=1 two cycles later.
REQ-033 Wrong-channel ack: sel=7 in flight, out_ack=16'h0040 -> ignored, out_valid stays 16'h0080; timeout not yet reached.
REQ-034 Timeout: TIMEOUT_CYC=8, sel=15, no ack -> err_timeout pulses once exactly 8 DRIVE cycles after entry, err_chan=15, out_valid=0.
REQ-035 Bad select: sel=5'd20, in_valid=1 -> err_sel pulse, err_chan=20, out_valid=0, data_out unchanged, in_ready stays 1.
REQ-036 Mid-flight reset: rst=0 during DRIVE on channel 2 -> all outputs 0 on that edge, no error pulse, data_out[47:32]=0.
REQ-037 Ack-timeout collision: TIMEOUT_CYC=4, out_ack[0]=1 on the terminal cycle -> no err_timeout, normal completion.
